// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: value input and display/status outputs of the scanned 7-segment driver
interface seg7_scan_display_if #(
   parameter int WIDTH_VALUE = 8,
   parameter int NUM_DIGITS  = 3
);
   logic [WIDTH_VALUE-1:0] value_i;
   logic [6:0]             seg_o;
   logic [NUM_DIGITS-1:0]  an_o;
   logic                   busy_o;
   logic                   ovf_o;
   modport master (output value_i, input seg_o, an_o, busy_o, ovf_o);
   modport slave  (input value_i, output seg_o, an_o, busy_o, ovf_o);
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: serial double-dabble binary-to-BCD plus multiplexed common-anode 7-seg scanner.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module seg7_scan_display #(
   parameter int WIDTH_VALUE = 8,
   parameter int NUM_DIGITS  = 3,
   parameter int REFRESH_DIV = 50000
) (
   input logic               clk_i,
   input logic               reset_i,
   seg7_scan_display_if.slave bus_if
);
   localparam int ND = (WIDTH_VALUE + 2) / 3;
   localparam int BW = 4 * ND;
   localparam int PW = 4 * ((ND > NUM_DIGITS) ? ND : NUM_DIGITS);
   localparam int CW = $clog2(WIDTH_VALUE + 1);
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int DW = 4 * NUM_DIGITS;
   typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;
   state_t                  state_q, state_d;
   logic [WIDTH_VALUE-1:0]  value_q, value_d;
   logic                    pending_q, pending_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW+WIDTH_VALUE-1:0] dab_q, dab_d, adj;
   logic [DW-1:0]           disp_q, disp_d;
   logic                    ovf_q, ovf_d;
   logic [RW-1:0]           rcnt_q, rcnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [PW-1:0]           pad;
   logic [3:0]              digit;
   logic                    wrap, blank;
   function automatic logic [6:0] seg_dec(input logic [3:0] d);
      case (d)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = 7'b1111111;
      endcase
   endfunction
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         value_q   <= '0;
         pending_q <= 1'b1;
         cnt_q     <= '0;
         dab_q     <= '0;
         disp_q    <= '0;
         ovf_q     <= 1'b0;
         rcnt_q    <= '0;
         idx_q     <= '0;
         seg_q     <= '1;
         an_q      <= '1;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         dab_q     <= dab_d;
         disp_q    <= disp_d;
         ovf_q     <= ovf_d;
         rcnt_q    <= rcnt_d;
         idx_q     <= idx_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end
   // BCD nibbles sit above the binary bits; correct them before each shift
   always_comb begin
      adj = dab_q;
      for (int i = 0; i < ND; i++)
         if (adj[WIDTH_VALUE+4*i +: 4] >= 4'd5) adj[WIDTH_VALUE+4*i +: 4] = adj[WIDTH_VALUE+4*i +: 4] + 4'd3;
      pad = PW'(dab_q[BW+WIDTH_VALUE-1:WIDTH_VALUE]);
   end
   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      pending_d = pending_q;
      cnt_d     = cnt_q;
      dab_d     = dab_q;
      disp_d    = disp_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: if (pending_q || bus_if.value_i != value_q) begin
            value_d   = bus_if.value_i;
            dab_d     = {BW'(0), bus_if.value_i};
            cnt_d     = '0;
            pending_d = 1'b0;
            state_d   = CONV;
         end
         CONV: begin
            dab_d   = adj << 1;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(WIDTH_VALUE - 1)) ? UPDATE : CONV;
         end
         UPDATE: begin
            disp_d  = pad[DW-1:0];
            ovf_d   = |(pad >> DW);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      wrap   = rcnt_q == RW'(REFRESH_DIV - 1);
      rcnt_d = wrap ? '0 : rcnt_q + 1'b1;
      idx_d  = wrap ? ((idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1) : idx_q;
      digit  = disp_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      blank  = (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
`else
      blank  = 1'b0;
`endif
      seg_d  = ovf_q ? 7'b0111111 : blank ? 7'b1111111 : seg_dec(digit);
      an_d   = ~(NUM_DIGITS'(1) << idx_q);
   end
   assign bus_if.seg_o  = seg_q;
   assign bus_if.an_o   = an_q;
   assign bus_if.busy_o = state_q != IDLE;
   assign bus_if.ovf_o  = ovf_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed checks of conversion timing, scanning, overflow and digit patterns.
module tb_seg7_scan_display;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'b1111111;
`else
   localparam logic [6:0] LZ = 7'b1000000;
`endif
   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0010000;
   localparam logic [6:0] DASH = 7'b0111111;
   seg7_scan_display_if #(.WIDTH_VALUE(8), .NUM_DIGITS(3)) ifa ();
   seg7_scan_display_if #(.WIDTH_VALUE(10), .NUM_DIGITS(3)) ifb ();
   seg7_scan_display #(.WIDTH_VALUE(8), .NUM_DIGITS(3), .REFRESH_DIV(4)) dut_a (
      .clk_i(clk), .reset_i(rst), .bus_if(ifa));
   seg7_scan_display #(.WIDTH_VALUE(10), .NUM_DIGITS(3), .REFRESH_DIV(4)) dut_b (
      .clk_i(clk), .reset_i(rst), .bus_if(ifb));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic read_digit(input bit use_b, input int k, output logic [6:0] s);
      logic [2:0] tgt;
      bit         found;
      tgt   = ~(3'b001 << k);
      found = 1'b0;
      s     = 7'h00;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if ((use_b ? ifb.an_o : ifa.an_o) == tgt) begin
            s     = use_b ? ifb.seg_o : ifa.seg_o;
            found = 1'b1;
         end
      end
      check("digit_timeout", found, 1);
   endtask
   task automatic digits(input string tag, input bit use_b, input logic [6:0] d2, d1, d0);
      logic [6:0] s;
      read_digit(use_b, 0, s); check({tag, "_d0"}, s, d0);
      read_digit(use_b, 1, s); check({tag, "_d1"}, s, d1);
      read_digit(use_b, 2, s); check({tag, "_d2"}, s, d2);
   endtask
   task automatic wait_idle(input bit use_b);
      int n;
      n = 0;
      @(negedge clk);
      while ((use_b ? ifb.busy_o : ifa.busy_o) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", n < 40, 1);
      @(negedge clk);
   endtask
   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n += int'(ifa.busy_o);
      end
   endtask
   initial begin
      int n;
      logic [2:0] prev;
      bit synced;
      logic [2:0] an_exp [4];
      logic [6:0] tbl100 [3];
      an_exp = '{3'b110, 3'b101, 3'b011, 3'b110};
      tbl100 = '{S0, S0, S1};
      ifa.value_i = '0;
      ifb.value_i = '0;
      repeat (3) @(negedge clk);
      check("rst_seg", ifa.seg_o, 7'h7f);
      check("rst_an", ifa.an_o, 3'b111);
      check("rst_busy", ifa.busy_o, 0);
      check("rst_ovf", ifa.ovf_o, 0);
      rst = 1'b0;
      count_busy(n);
      check("boot_busy_cycles", n, 9);
      digits("zero", 0, LZ, LZ, S0);
      // lock onto the first cycle of digit 0, then follow the scan
      synced = 1'b0;
      prev = ifa.an_o;
      for (int i = 0; i < 40 && !synced; i++) begin
         @(negedge clk);
         synced = (ifa.an_o == 3'b110) && (prev != 3'b110);
         prev = ifa.an_o;
      end
      check("scan_sync", synced, 1);
      for (int j = 0; j < 16; j++) begin
         check($sformatf("an_seq%0d", j), ifa.an_o, an_exp[j/4]);
         @(negedge clk);
      end
      ifa.value_i = 8'd173;
      @(negedge clk);
      check("v173_busy_start", ifa.busy_o, 1);
      repeat (8) @(negedge clk);
      check("v173_busy_last", ifa.busy_o, 1);
      @(negedge clk);
      check("v173_busy_done", ifa.busy_o, 0);
      digits("v173", 0, S1, S7, S3);
      ifa.value_i = 8'd100;
      repeat (3) @(negedge clk);
      ifa.value_i = 8'd200;
      repeat (7) @(negedge clk);
      check("v100_done", ifa.busy_o, 0);
      @(negedge clk);
      check("v200_start", ifa.busy_o, 1);
      for (int j = 0; j < 10; j++) begin
         int k;
         k = (ifa.an_o == 3'b110) ? 0 : (ifa.an_o == 3'b101) ? 1 : 2;
         check($sformatf("v100_win%0d", j), ifa.seg_o, tbl100[k]);
         @(negedge clk);
      end
      wait_idle(0);
      digits("v200", 0, S2, S0, S0);
      ifa.value_i = 8'd5;
      wait_idle(0);
      digits("v5", 0, LZ, LZ, S5);
      ifa.value_i = 8'd42;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", ifa.busy_o, 0);
      check("midrst_seg", ifa.seg_o, 7'h7f);
      check("midrst_an", ifa.an_o, 3'b111);
      rst = 1'b0;
      count_busy(n);
      check("midrst_busy_cycles", n, 9);
      digits("v42", 0, LZ, S4, S2);
      ifb.value_i = 10'd1000;
      wait_idle(1);
      check("v1000_ovf", ifb.ovf_o, 1);
      digits("v1000", 1, DASH, DASH, DASH);
      ifb.value_i = 10'd999;
      wait_idle(1);
      check("v999_ovf", ifb.ovf_o, 0);
      digits("v999", 1, S9, S9, S9);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Display-side consumer for the step up/down switch counter: converts its binary count to decimal and drives a multiplexed, common-anode 7-segment display.
- A sequential double-dabble converter (one bit per clock) runs a state machine and updates a BCD display register.
- A refresh scanner cycles the digit anodes and drives the matching segment pattern.
- Sits between the counter output and the board display pins.

Parameters:
- WIDTH_VALUE, 8, width of the binary input value.
- NUM_DIGITS, 3, number of physical display digits (2..8).
- REFRESH_DIV, 50000, clock cycles each digit stays lit (>=2).

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  reset, active-high, synchronous to clk_i
- value_i  input  WIDTH_VALUE  unsigned binary value to display
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low
- an_o  output  NUM_DIGITS  digit anodes, active-low one-hot; an_o[0] is the least significant digit
- busy_o  output  1  conversion in progress
- ovf_o  output  1  value does not fit in NUM_DIGITS decimal digits

Behaviour:
- Clocking and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values:
  - seg_o = all 1s (segments off); an_o = all 1s; busy_o = 0; ovf_o = 0.
  - BCD register = 0; digit index = 0; refresh counter = 0.
  - Pending flag set to 1, so one conversion runs after reset release.
- Converter FSM states: IDLE, CONV, UPDATE.
  - IDLE: if pending, or value_i != value_q, then on edge N: value_q <= value_i, load shift register, bit counter = 0, clear pending, go to CONV.
  - CONV: WIDTH_VALUE cycles (edges N+1..N+WIDTH_VALUE). Each cycle: add 3 to every internal BCD nibble >= 5, then shift left one bit.
  - UPDATE: edge N+WIDTH_VALUE+1 writes the BCD register and ovf_o, then returns to IDLE.
- busy_o = 1 in CONV and UPDATE, 0 in IDLE.
- Internal BCD width: 4*((WIDTH_VALUE+2)/3) bits, always sufficient for the full input range.
- Overflow: ovf_o = 1 when any internal digit above NUM_DIGITS-1 is nonzero. While ovf_o = 1, every digit shows a dash (7'b0111111).
- Input changes during CONV/UPDATE do not disturb the conversion in progress. The FSM re-evaluates in IDLE, so only the latest value is converted next. No value is lost permanently; intermediate values may be skipped.
- Scanner:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index advances; it wraps from NUM_DIGITS-1 to 0.
  - Runs continuously, independent of the FSM.
- Outputs seg_o/an_o are registered: they reflect the digit index and BCD register one cycle later.
  - Value applied before edge N appears on seg_o at edge N+WIDTH_VALUE+2.
- Segment decode (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other code = 1111111 (blank).
- Reset mid-conversion aborts to the reset state and forces one fresh conversion afterwards.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN
- Defined: any zero digit above the most significant nonzero digit is blanked (seg_o = 1111111 while its anode is active). Digit 0 is never blanked; value 0 shows a single "0". Blanking does not apply while ovf_o = 1.
- Undefined: all NUM_DIGITS digits show their decoded value, including leading zeros.

Test Plan:
- Reset held 3 cycles, then released with value_i=0:
  - During reset: seg_o=1111111, an_o=111, busy_o=0.
  - busy_o=1 for exactly 9 cycles (8 CONV + 1 UPDATE).
  - Digits then show 0,0,0 (feature off).
- REFRESH_DIV=4, NUM_DIGITS=3: an_o sequence 110, 101, 011, 110, each held exactly 4 cycles.
- value_i=173 (feature off):
  - Digit 0 = 0110000 ("3"), digit 1 = 1111000 ("7"), digit 2 = 1111001 ("1").
  - Update lands 10 cycles after the change.
- value_i=100, then 200 three cycles into CONV:
  - The 100 conversion completes and is displayed.
  - A second conversion starts the cycle after returning to IDLE.
  - Final display 2,0,0.
- WIDTH_VALUE=10, NUM_DIGITS=3, value_i=1000: ovf_o=1, all digits 0111111; then value_i=999 gives ovf_o=0 and display 9,9,9.
- value_i=5 with LEADING_ZERO_BLANK_EN defined: digits 2 and 1 show 1111111, digit 0 shows 0010010. Without the macro, digits 2 and 1 show 1000000.
